// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, controller states and byte-enable patterns.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational little-endian lane steering for stores and lane extraction/extension for loads.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_lo,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data_in,
    output logic [31:0] st_data_out,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    input  logic [31:0] ld_data_in,
    output logic [31:0] ld_data_out
);

    logic [7:0]  rd_lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = ld_data_in[8*gi +: 8];
        end
    endgenerate

    // Sub-word store data is replicated so every lane carries it; be picks the live one.
    always_comb begin
        st_data_out = st_data_in;
        st_be       = BE_WORD;
        case (st_size)
            SZ_BYTE: begin
                st_data_out = {4{st_data_in[7:0]}};
                st_be       = BE_BYTE0 << st_lo;
            end
            SZ_HALF: begin
                st_data_out = {2{st_data_in[15:0]}};
                st_be       = st_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte     = rd_lane[ld_lo];
        ld_half     = ld_lo[1] ? ld_data_in[31:16] : ld_data_in[15:0];
        ld_data_out = ld_data_in;
        case (ld_size)
            SZ_BYTE: ld_data_out = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_out = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: IDLE/REQ/DONE data-memory controller with stall, timeout and error pulse.
// Define MEM_SUBWORD_EN for byte/half accesses; otherwise every access is a word.
module mem_stage
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [1:0]  MemSize_M,
    input  logic        MemSigned_M,
    input  logic [31:0] ALUOut_M,
    input  logic [31:0] WriteData_M,
    output logic [31:0] ReadData_M,
    output logic        Stall_M,
    output logic        MemErr_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [1:0]    size_eff;
    logic          signed_eff;
    logic          misalign;
    logic          access, illegal, legal;
    logic          stall_c, err_idle_c;
    logic [31:0]   st_data, ld_data;
    logic [3:0]    st_be;

`ifdef MEM_SUBWORD_EN
    assign size_eff   = MemSize_M;
    assign signed_eff = MemSigned_M;
    always_comb begin
        misalign = 1'b0;
        case (MemSize_M)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = ALUOut_M[0];
            SZ_WORD: misalign = |ALUOut_M[1:0];
            default: misalign = 1'b1;
        endcase
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{MemSize_M, MemSigned_M};
    assign size_eff   = SZ_WORD;
    assign signed_eff = 1'b0;
    assign misalign   = |ALUOut_M[1:0];
`endif

    assign access  = MemRead_M | MemWrite_M;
    assign illegal = access & (misalign | (MemRead_M & MemWrite_M));
    assign legal   = access & ~illegal;

    mem_align u_align (
        .st_lo       (ALUOut_M[1:0]),
        .st_size     (size_eff),
        .st_data_in  (WriteData_M),
        .st_data_out (st_data),
        .st_be       (st_be),
        .ld_lo       (addr_q[1:0]),
        .ld_size     (size_q),
        .ld_signed   (signed_q),
        .ld_data_in  (dmem_rdata),
        .ld_data_out (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        size_d     = size_q;
        signed_d   = signed_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        stall_c    = 1'b0;
        err_idle_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (legal) begin
                    stall_c  = 1'b1;
                    addr_d   = ALUOut_M;
                    wdata_d  = st_data;
                    be_d     = st_be;
                    we_d     = MemWrite_M;
                    size_d   = size_eff;
                    signed_d = signed_eff;
                    cnt_d    = '0;
                    state_d  = ST_REQ;
                end else begin
                    err_idle_c = illegal;
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                if (dmem_ack) begin
                    rdata_d = we_q ? 32'h0 : ld_data;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Input-driven outputs are gated so reset forces them low without waiting for a clock.
    assign Stall_M    = rst_n & stall_c;
    assign MemErr_M   = rst_n & (err_idle_c | ((state_q == ST_DONE) & err_q));
    assign dmem_req   = (state_q == ST_REQ);
    assign dmem_we    = (state_q == ST_REQ) & we_q;
    assign dmem_addr  = word_align(addr_q);
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign ReadData_M = rdata_q;

endmodule
